// File: rtl/window3x3_stream_if.sv
// Stream interface for the 3x3 window extractor: raster pixel input plus
// registered window output with centre coordinates and end-of-frame pulse.
interface window3x3_stream_if #(
   parameter int DATA_W = 8,
   parameter int COL_W  = 8,
   parameter int ROW_W  = 8
);
   logic                  din_valid;
   logic                  din_sof;
   logic [DATA_W-1:0]     din;
   logic [9*DATA_W-1:0]   win;
   logic                  win_valid;
   logic [COL_W-1:0]      win_col;
   logic [ROW_W-1:0]      win_row;
   logic                  frame_done;

   modport master (
      output din_valid, din_sof, din,
      input  win, win_valid, win_col, win_row, frame_done
   );

   modport slave (
      input  din_valid, din_sof, din,
      output win, win_valid, win_col, win_row, frame_done
   );
endinterface

// File: rtl/window3x3_stream.sv
// 3x3 sliding-window extractor over a raster pixel stream, two line buffers,
// stall tolerant, with frame restart on sof and no windows straddling rows.
module window3x3_stream #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int COL_W  = $clog2(IMG_W),
   parameter int ROW_W  = $clog2(IMG_H)
) (
   input  logic             clk,
   input  logic             rst,
   window3x3_stream_if.slave s
);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  cur_col;
   logic [ROW_W-1:0]  cur_row;
   logic              beat;
   logic              qual;
   logic              last_px;
   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [DATA_W-1:0] lb2 [IMG_W];
   logic [DATA_W-1:0] lb1_rd;
   logic [DATA_W-1:0] lb2_rd;
   logic [DATA_W-1:0] w     [9];
   logic [DATA_W-1:0] w_nxt [9];

   // sof overrides the counters so the flagged beat is always pixel (0,0)
   assign beat    = s.din_valid;
   assign cur_col = s.din_sof ? '0 : col;
   assign cur_row = s.din_sof ? '0 : row;
   assign lb1_rd  = lb1[cur_col];
   assign lb2_rd  = lb2[cur_col];
   assign qual    = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
   assign last_px = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         w_nxt[3*r]     = w[3*r+1];
         w_nxt[3*r + 1] = w[3*r+2];
      end
      w_nxt[2] = lb2_rd;
      w_nxt[5] = lb1_rd;
      w_nxt[8] = s.din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (beat) begin
         if (cur_col == COL_LAST) begin
            col <= '0;
            row <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
         end else begin
            col <= cur_col + COL_W'(1);
            row <= cur_row;
         end
      end
   end

   // Line buffers carry no reset; rows below 2 are never qualified, so
   // stale contents cannot reach the output.
   always_ff @(posedge clk) begin
      if (beat) begin
         lb2[cur_col] <= lb1_rd;
         lb1[cur_col] <= s.din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 9; k++) w[k] <= '0;
         s.win        <= '0;
         s.win_valid  <= 1'b0;
         s.win_col    <= '0;
         s.win_row    <= '0;
         s.frame_done <= 1'b0;
      end else begin
         s.win_valid  <= beat && qual;
         s.frame_done <= beat && last_px;
         if (beat) begin
            for (int k = 0; k < 9; k++) w[k] <= w_nxt[k];
            // Output copy only updates on qualified beats so it holds otherwise
            if (qual) begin
               for (int k = 0; k < 9; k++) s.win[k*DATA_W +: DATA_W] <= w_nxt[k];
               s.win_col <= cur_col - COL_W'(1);
               s.win_row <= cur_row - ROW_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_window3x3_stream.sv
// Scoreboard bench for window3x3_stream: an 8x6 instance for the main
// scenarios and a 3x3 instance for the minimum-size case.
module tb_window3x3_stream;
   localparam int W = 8;
   localparam int H = 6;

   typedef struct {
      logic [71:0] win;
      int          col;
      int          row;
      bit          fd;
      int          cyc;
   } exp_t;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic rst3 = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   window3x3_stream_if #(.DATA_W(8), .COL_W(3), .ROW_W(3)) ifa ();
   window3x3_stream_if #(.DATA_W(8), .COL_W(2), .ROW_W(2)) ifb ();

   window3x3_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut_a (
      .clk(clk), .rst(rst), .s(ifa));
   window3x3_stream #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) dut_b (
      .clk(clk), .rst(rst3), .s(ifb));

   int tests = 0;
   int fails = 0;
   int wins_a = 0, fd_a = 0, wins_b = 0, fd_b = 0;
   bit done_b = 0;
   bit capture_first = 0;
   logic [71:0] first_win;
   logic [2:0]  first_col, first_row;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int mr = 0, mc = 0;
   logic [7:0] img [H][W];

   task automatic chk(input string name, input logic [71:0] got, input logic [71:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (ifa.win_valid) wins_a++;
         if (ifa.frame_done) fd_a++;
         if (ifa.win_valid && capture_first) begin
            first_win = ifa.win;
            first_col = ifa.win_col;
            first_row = ifa.win_row;
            capture_first = 0;
         end
         if (qa.size() > 0 && qa[0].cyc == cyc) begin
            ea = qa.pop_front();
            tests++;
            if (ifa.win_valid !== 1'b1 || ifa.win !== ea.win || int'(ifa.win_col) != ea.col ||
                int'(ifa.win_row) != ea.row || ifa.frame_done !== ea.fd) begin
               fails++;
               $display("FAIL win_a cyc=%0d: got v=%0b win=%h c=%0d r=%0d fd=%0b want v=1 win=%h c=%0d r=%0d fd=%0b",
                        cyc, ifa.win_valid, ifa.win, ifa.win_col, ifa.win_row, ifa.frame_done,
                        ea.win, ea.col, ea.row, ea.fd);
            end
         end else if (ifa.win_valid !== 1'b0 || ifa.frame_done !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL spurious_a cyc=%0d: got v=%0b fd=%0b want v=0 fd=0",
                     cyc, ifa.win_valid, ifa.frame_done);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst3) begin
         if (ifb.win_valid) wins_b++;
         if (ifb.frame_done) fd_b++;
         if (qb.size() > 0 && qb[0].cyc == cyc) begin
            eb = qb.pop_front();
            tests++;
            if (ifb.win_valid !== 1'b1 || ifb.win !== eb.win || int'(ifb.win_col) != eb.col ||
                int'(ifb.win_row) != eb.row || ifb.frame_done !== eb.fd) begin
               fails++;
               $display("FAIL win_b cyc=%0d: got v=%0b win=%h c=%0d r=%0d fd=%0b want v=1 win=%h c=%0d r=%0d fd=%0b",
                        cyc, ifb.win_valid, ifb.win, ifb.win_col, ifb.win_row, ifb.frame_done,
                        eb.win, eb.col, eb.row, eb.fd);
            end
         end else if (ifb.win_valid !== 1'b0 || ifb.frame_done !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL spurious_b cyc=%0d: got v=%0b fd=%0b want v=0 fd=0",
                     cyc, ifb.win_valid, ifb.frame_done);
         end
      end
   end

   task automatic idle_a(input int n);
      for (int i = 0; i < n; i++) begin
         ifa.din_valid = 1'b0;
         ifa.din_sof   = 1'($urandom_range(0, 1));
         ifa.din       = 8'($urandom);
         @(posedge clk); #1;
      end
      ifa.din_sof = 1'b0;
   endtask

   // Pixel value is off + row*16 + col of the position the model expects.
   task automatic frame_a(input logic [7:0] off, input bit sof, input bit stall, input int n_px);
      bit s;
      int g;
      logic [7:0] px;
      exp_t e;
      for (int i = 0; i < n_px; i++) begin
         s = sof && (i == 0);
         if (s) begin
            mr = 0;
            mc = 0;
         end
         if (stall) begin
            if (mc == 0 || mc == 4) g = $urandom_range(1, 2);
            else g = ($urandom_range(0, 99) < 40) ? $urandom_range(1, 2) : 0;
            idle_a(g);
         end
         px = off + 8'(mr*16 + mc);
         ifa.din_valid = 1'b1;
         ifa.din_sof   = s;
         ifa.din       = px;
         img[mr][mc]   = px;
         if (mr >= 2 && mc >= 2) begin
            for (int k = 0; k < 9; k++) e.win[k*8 +: 8] = img[mr-2+k/3][mc-2+k%3];
            e.col = mc - 1;
            e.row = mr - 1;
            e.fd  = (mr == H-1) && (mc == W-1);
            e.cyc = cyc + 1;
            qa.push_back(e);
         end
         if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
         end else begin
            mc++;
         end
         @(posedge clk); #1;
         ifa.din_valid = 1'b0;
         ifa.din_sof   = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, f0;
      ifa.din_valid = 1'b0;
      ifa.din_sof   = 1'b0;
      ifa.din       = '0;
      #2;
      chk("rst_win_a",   ifa.win, 72'd0);
      chk("rst_valid_a", 72'(ifa.win_valid), 72'd0);
      chk("rst_pos_a",   72'({ifa.win_col, ifa.win_row, ifa.frame_done}), 72'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // continuous frame
      w0 = wins_a; f0 = fd_a; capture_first = 1;
      frame_a(8'h00, 1, 0, W*H);
      idle_a(3);
      chk("p1_first_win", first_win, 72'h22_21_20_12_11_10_02_01_00);
      chk("p1_first_col", 72'(first_col), 72'd1);
      chk("p1_first_row", 72'(first_row), 72'd1);
      chk("p1_windows",   72'(wins_a - w0), 72'd24);
      chk("p1_frame_done", 72'(fd_a - f0), 72'd1);

      // stalled frame, gaps at line wrap and mid-line
      w0 = wins_a; f0 = fd_a;
      frame_a(8'h00, 1, 1, W*H);
      idle_a(3);
      chk("p2_windows",   72'(wins_a - w0), 72'd24);
      chk("p2_frame_done", 72'(fd_a - f0), 72'd1);

      // back-to-back frames, sof only on the first
      w0 = wins_a; f0 = fd_a;
      frame_a(8'h00, 1, 0, W*H);
      frame_a(8'h80, 0, 0, W*H);
      idle_a(3);
      chk("p3_windows",   72'(wins_a - w0), 72'd48);
      chk("p3_frame_done", 72'(fd_a - f0), 72'd2);

      // abort with sof where (3,5) would be, then a full frame
      w0 = wins_a; f0 = fd_a;
      frame_a(8'h00, 1, 0, 3*W + 5);
      frame_a(8'h40, 1, 0, W*H);
      idle_a(3);
      chk("p4_windows",   72'(wins_a - w0), 72'd33);
      chk("p4_frame_done", 72'(fd_a - f0), 72'd1);

      // reset after pixel (4,3), then a frame without sof
      w0 = wins_a; f0 = fd_a;
      frame_a(8'h00, 1, 0, 4*W + 4);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk("p5_rst_win",   ifa.win, 72'd0);
      chk("p5_rst_valid", 72'(ifa.win_valid), 72'd0);
      chk("p5_rst_pos",   72'({ifa.win_col, ifa.win_row, ifa.frame_done}), 72'd0);
      qa.delete();
      mr = 0; mc = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      frame_a(8'h20, 0, 0, W*H);
      idle_a(3);
      chk("p5_windows",   72'(wins_a - w0), 72'd38);
      chk("p5_frame_done", 72'(fd_a - f0), 72'd1);
      chk("qa_drained",   72'(qa.size()), 72'd0);

      for (int i = 0; i < 1000 && !done_b; i++) @(posedge clk);
      chk("b_finished", 72'(done_b), 72'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      exp_t e;
      logic [7:0] base;
      ifb.din_valid = 1'b0;
      ifb.din_sof   = 1'b0;
      ifb.din       = '0;
      #2;
      chk("rst_win_b", ifb.win, 72'd0);
      @(negedge clk);
      rst3 = 1'b0;
      @(posedge clk); #1;
      for (int f = 0; f < 2; f++) begin
         base = (f == 0) ? 8'h30 : 8'h60;
         for (int i = 0; i < 9; i++) begin
            if (f == 1 && i == 4) begin
               ifb.din_valid = 1'b0;
               @(posedge clk); #1;
            end
            ifb.din_valid = 1'b1;
            ifb.din_sof   = (f == 0) && (i == 0);
            ifb.din       = base + 8'(i);
            if (i == 8) begin
               for (int k = 0; k < 9; k++) e.win[k*8 +: 8] = base + 8'(k);
               e.col = 1;
               e.row = 1;
               e.fd  = 1;
               e.cyc = cyc + 1;
               qb.push_back(e);
            end
            @(posedge clk); #1;
            ifb.din_valid = 1'b0;
            ifb.din_sof   = 1'b0;
         end
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("b_windows",    72'(wins_b), 72'd2);
      chk("b_frame_done", 72'(fd_b), 72'd2);
      chk("qb_drained",   72'(qb.size()), 72'd0);
      done_b = 1;
   end
endmodule

// File: doc/window3x3_stream.md
Name: window3x3_stream

Overview:
- Parametrised successor to the fixed 256-wide 8-bit 3x3 window extractor, used by the SIFT Gaussian/DoG and extremum stages.
- Takes a raster pixel stream with per-pixel valid and start-of-frame, buffers two lines, and emits a registered 3x3 window with its own valid.
- Emits centre-pixel coordinates and an end-of-frame pulse.
- Unlike the fixed version, it tolerates input stalls, restarts cleanly on frame boundaries, and never emits windows that straddle rows or frames.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 256: pixels per line; must be >= 3.
- IMG_H, 256: lines per frame; must be >= 3.
- COL_W, $clog2(IMG_W): column counter width (derived; do not override).
- ROW_W, $clog2(IMG_H): row counter width (derived; do not override).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- din_valid  in  1  din is accepted on every cycle this is high; no backpressure.
- din_sof  in  1  qualifies a din_valid beat as pixel (0,0) of a new frame.
- din  in  DATA_W  pixel data.
- win  out  9*DATA_W  window; slice k = win[k*DATA_W +: DATA_W], row-major, k=0 top-left, k=8 bottom-right (newest pixel).
- win_valid  out  1  win, win_col and win_row are valid this cycle.
- win_col  out  COL_W  column of the window centre.
- win_row  out  ROW_W  row of the window centre.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (async assert, sync release): counters, window registers, win_valid, win_col, win_row and frame_done all go to 0. Line-buffer contents are don't-care, because qualification never exposes them before they are refilled.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accepted beats.
  - col wraps to 0 at IMG_W-1 and increments row.
  - Both wrap to 0 after pixel (IMG_H-1, IMG_W-1), so the next beat is implicitly (0,0) of a new frame.
- Line buffers: two IMG_W-deep buffers, LB1 (row-1) and LB2 (row-2), addressed by col.
  - On an accepted beat, read-before-write at address col: LB2[col] <= LB1[col] and LB1[col] <= din.
  - Old values feed the window column shift. Registers or inferred RAM are both acceptable, provided read-before-write holds.
- Window: 3x3 register array. On an accepted beat, each row shifts left and new column {LB2[col], LB1[col], din} enters at the right (k=2,5,8). On non-accepted cycles all state holds.
- Qualification and latency: an accepted beat at (r,c) with r>=2 and c>=2 causes, on the next cycle:
  - win_valid=1 with the window covering rows r-2..r and cols c-2..c;
  - win_row=r-1 and win_col=c-1.
  - Latency is 1 cycle, and throughput is 1 window per accepted beat.
  - On all other cycles win_valid=0, and win/win_col/win_row hold their last values.
- Window count: exactly (IMG_W-2)*(IMG_H-2) windows per complete frame. No window is emitted for c<2 (the left edge does not wrap onto the previous row) or for r<2.
- din_sof with din_valid: forces that beat to (0,0), whatever the counter state.
  - A mid-frame sof aborts the current frame with no frame_done pulse.
  - Stale line-buffer data is never qualified, because row restarts at 0.
- din_sof without din_valid is ignored.
- frame_done: 1-cycle pulse on the cycle after the beat at (IMG_H-1, IMG_W-1) is accepted. It coincides with that frame's last win_valid.
- Stalls: any pattern of din_valid gaps, including mid-line or at line wrap, yields windows bit-identical to the gap-free stream.
- Reset mid-frame: the same as power-up. The first beat after reset is (0,0) even without sof.
- Arithmetic: no pixel arithmetic; data passes through unmodified at DATA_W.

Test Plan:
- IMG_W=8, IMG_H=6, DATA_W=8, din=row*16+col, continuous valid:
  - first win_valid 1 cycle after pixel (2,2), carrying win = {0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22}, win_row=1, win_col=1;
  - exactly 24 windows in the frame;
  - frame_done asserted with the (row 4, col 6) window.
- Same image with random din_valid duty (30-90%), gaps placed at line wrap and mid-line -> window sequence identical to the continuous run; win_valid never asserted during or one cycle after a gap.
- Back-to-back frames, second frame = first + 0x80, no idle cycles, sof only on frame 1 -> 48 windows total. The first frame-2 window appears only after frame-2 pixel (2,2) and contains no frame-1 data.
- sof mid-frame at (3,5), then a full frame -> no frame_done for the aborted frame; the next win_valid comes after new pixel (2,2); 24 windows follow.
- rst pulsed at (4,3), then a stream without sof -> outputs 0 during reset; the first beat is treated as (0,0); 24 correct windows.
- IMG_W=3, IMG_H=3 -> exactly 1 window (centre (1,1), win = all 9 pixels in order), with frame_done in the same cycle.
